// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU decode-and-execute stage with a valid/ready
// result register. Defining ALU_MUL_EN adds an iterative shift-add multiplier
// (MUL state, busy output, ALUControl code 1010); without it the unit is
// purely single-cycle and busy is tied low.
//
// state | meaning
// IDLE  | accepting requests whenever the result register is free or draining
// MUL   | multiplier iterating one bit per cycle, requests blocked
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            opcode,
  input  logic [2:0]            fn3,
  input  logic [6:0]            fn7,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic [3:0]            ALUControl,
  output logic                  busy
);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLL  = 4'b0110;
  localparam logic [3:0] C_SRL  = 4'b0111;
  localparam logic [3:0] C_SRA  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] C_MUL  = 4'b1010;
`endif

  logic [3:0]            dec_ctrl;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;

  // Only opcode[5] and fn7[5] steer the base decode; the rest is sunk here.
  logic unused_bits;
  assign unused_bits = ^{opcode[6], opcode[4:0], fn7[6], fn7[4:0]};

  assign shamt  = srcB[SHAMT_W-1:0];
  assign zero   = (result == '0);
  assign accept = in_valid & in_ready;

  // Main-decoder class plus funct fields to ALU control code.
  always_comb begin
    dec_ctrl = C_ADD;
    case (ALUOp)
      2'b01: begin
        case (fn3[2:1])
          2'b10:   dec_ctrl = C_SLT;
          2'b11:   dec_ctrl = C_SLTU;
          default: dec_ctrl = C_SUB;
        endcase
      end
      2'b10: begin
        case (fn3)
          3'b000:  dec_ctrl = (opcode[5] & fn7[5]) ? C_SUB : C_ADD;
          3'b001:  dec_ctrl = C_SLL;
          3'b010:  dec_ctrl = C_SLT;
          3'b011:  dec_ctrl = C_SLTU;
          3'b100:  dec_ctrl = C_XOR;
          3'b101:  dec_ctrl = fn7[5] ? C_SRA : C_SRL;
          3'b110:  dec_ctrl = C_OR;
          default: dec_ctrl = C_AND;
        endcase
`ifdef ALU_MUL_EN
        // M-extension encoding: only funct3=000 is supported, others fall back to add.
        if (opcode[5] && (fn7 == 7'b0000001)) begin
          dec_ctrl = (fn3 == 3'b000) ? C_MUL : C_ADD;
        end
`endif
      end
      default: dec_ctrl = C_ADD;
    endcase
  end

  // Single-cycle execute for every code except mul.
  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      C_ADD:   alu_res = srcA + srcB;
      C_SUB:   alu_res = srcA - srcB;
      C_AND:   alu_res = srcA & srcB;
      C_OR:    alu_res = srcA | srcB;
      C_XOR:   alu_res = srcA ^ srcB;
      C_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      C_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (srcA < srcB)};
      C_SLL:   alu_res = srcA << shamt;
      C_SRL:   alu_res = srcA >> shamt;
      C_SRA:   alu_res = $unsigned($signed(srcA) >>> shamt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  dec_mul;
  logic                  mul_done;
  logic [SHAMT_W-1:0]    mul_cnt;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc, acc_next;

  assign dec_mul  = (dec_ctrl == C_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake and busy.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !out_valid | out_ready;
        if (in_valid && in_ready && dec_mul) state_d = S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (mul_cnt == '0) begin
          mul_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Result register and shift-add multiplier datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ALUControl <= C_ADD;
      mul_cnt    <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      if (dec_mul) begin
        mcand     <= srcA;
        mplier    <= srcB;
        acc       <= '0;
        mul_cnt   <= SHAMT_W'(DATA_WIDTH - 1);
        out_valid <= 1'b0;
      end else begin
        result     <= alu_res;
        ALUControl <= dec_ctrl;
        out_valid  <= 1'b1;
      end
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (mul_done) begin
        result     <= acc_next;
        ALUControl <= C_MUL;
        out_valid  <= 1'b1;
      end else begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid | out_ready;
  assign busy     = 1'b0;

  // Result register: load on accept, drop on consume, kill on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ALUControl <= C_ADD;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      result     <= alu_res;
      ALUControl <= dec_ctrl;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes the reference
// model's answer when a request is accepted, the monitor checks every
// presented result against the queue head. Mul tests need ALU_MUL_EN.
module tb_alu_exec_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [1:0]    ALUOp;
  logic [6:0]    opcode, fn7;
  logic [2:0]    fn3;
  logic [DW-1:0] srcA, srcB, result;
  logic [3:0]    ALUControl;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;

  alu_exec_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .opcode(opcode), .fn3(fn3), .fn7(fn7), .srcA(srcA), .srcB(srcB),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .ALUControl(ALUControl), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: decode table and plain arithmetic on 32-bit values.
  function automatic void model(input logic [1:0] op, input logic [6:0] opc,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] code, output logic [31:0] res);
    int unsigned sh;
    logic [63:0] prod;
    sh   = int'(b % 32);
    code = 4'd0;
    if (op == 2'b01) begin
      if (f3[2:1] == 2'b10)      code = 4'd5;
      else if (f3[2:1] == 2'b11) code = 4'd9;
      else                       code = 4'd1;
    end else if (op == 2'b10) begin
      case (f3)
        3'd0: code = (opc[5] && f7[5]) ? 4'd1 : 4'd0;
        3'd1: code = 4'd6;
        3'd2: code = 4'd5;
        3'd3: code = 4'd9;
        3'd4: code = 4'd4;
        3'd5: code = f7[5] ? 4'd8 : 4'd7;
        3'd6: code = 4'd3;
        default: code = 4'd2;
      endcase
`ifdef ALU_MUL_EN
      if (opc[5] && f7 == 7'b0000001) code = (f3 == 3'd0) ? 4'd10 : 4'd0;
`endif
    end
    prod = {32'd0, a} * {32'd0, b};
    case (code)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd6:  res = a << sh;
      4'd7:  res = a >> sh;
      4'd8:  res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd9:  res = (a < b) ? 32'd1 : 32'd0;
      default: res = prod[31:0];
    endcase
  endfunction

  // One request attempt in one cycle; pushes the expectation when accepted.
  task automatic issue(input logic [1:0] op, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, output bit acc);
    exp_t        e;
    logic [3:0]  c;
    logic [31:0] r;
    @(negedge clk);
    in_valid = 1'b1; ALUOp = op; opcode = opc; fn3 = f3; fn7 = f7;
    srcA = a; srcB = b; out_ready = ordy;
    #1;
    acc = in_ready && !flush && !rst;
    if (acc) begin
      model(op, opc, f3, f7, a, b, c, r);
      e.res = r; e.code = c;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Retry until accepted, with random consumer readiness.
  task automatic send(input logic [1:0] op, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    bit acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++)
      issue(op, opc, f3, f7, a, b, 1'($urandom_range(0, 1)), acc);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: request not accepted in 100 cycles");
    end
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
    end
  endtask

  // Monitor: compare the presented result against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: result 0x%08h with no pending expectation", result);
        end else begin
          check("sb_result", result, sb[0].res);
          check("sb_ctrl", {28'd0, ALUControl}, {28'd0, sb[0].code});
          check("sb_zero", {31'd0, zero}, {31'd0, (sb[0].res == 32'd0)});
          if (out_ready) begin
            void'(sb.pop_front());
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          n0;
    logic [31:0] a, b;
    logic [6:0]  f7r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = '0; opcode = '0; fn3 = '0; fn7 = '0; srcA = '0; srcB = '0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_ctrl", {28'd0, ALUControl}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // R-type sub 5-5
    issue(2'b10, 7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd5, 1'b1, acc);
    check("sub_accept", {31'd0, acc}, 32'd1);
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_result", result, 32'd0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_ctrl", {28'd0, ALUControl}, 32'd1);

    // sra by 4, then slt/sltu on -1 vs 1
    issue(2'b10, 7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'h24, 1'b1, acc);
    check("sra_result", result, 32'hF800_0000);
    check("sra_ctrl", {28'd0, ALUControl}, 32'd8);
    issue(2'b10, 7'b0110011, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 1'b1, acc);
    check("slt_result", result, 32'd1);
    issue(2'b10, 7'b0110011, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 1'b1, acc);
    check("sltu_result", result, 32'd0);
    check("sltu_zero", {31'd0, zero}, 32'd1);
    drain();

    // Stream 8 single-cycle ops with the consumer always ready
    n0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      issue(2'b10, 7'b0110011, 3'($urandom_range(1, 7)), 7'b0000000, $urandom, $urandom, 1'b1, acc);
      check("stream_accept", {31'd0, acc}, 32'd1);
    end
    drain();
    check("stream_count", n_pop - n0, 32'd8);

    // Backpressure: hold the result for 3 cycles
    issue(2'b10, 7'b0110011, 3'b000, 7'b0000000, 32'd100, 32'd23, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ALUOp = 2'b00; srcA = 32'd7; srcB = 32'd9; out_ready = 1'b0;
      #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold", result, 32'd123);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    drain();

    // Flush kills a held result and discards a same-cycle request
    issue(2'b00, 7'b0000011, 3'b010, 7'b0000000, 32'h10, 32'h4, 1'b0, acc);
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; srcA = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_MUL_EN
    // Mul: busy for DATA_WIDTH cycles, blocks other requests
    begin
      int nb = 0;
      issue(2'b10, 7'b0110011, 3'b000, 7'b0000001, 32'h0001_0003, 32'h5, 1'b1, acc);
      check("mul_accept", {31'd0, acc}, 32'd1);
      in_valid = 1'b1; ALUOp = 2'b00;
      for (int k = 0; k < 60 && !out_valid; k++) begin
        if (busy) nb++;
        if (in_ready) begin
          n_tests++; n_fail++;
          $display("FAIL mul_block: in_ready 1, expected 0 during MUL");
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("mul_busy_cycles", nb, 32'd32);
      check("mul_result", result, 32'h0005_000F);
      check("mul_ctrl", {28'd0, ALUControl}, 32'd10);
      check("mul_busy_done", {31'd0, busy}, 32'd0);
      drain();
    end

    // Flush at MUL iteration 10
    issue(2'b10, 7'b0110011, 3'b000, 7'b0000001, 32'd1234, 32'd77, 1'b1, acc);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    check("mflush_busy", {31'd0, busy}, 32'd0);
    check("mflush_valid", {31'd0, out_valid}, 32'd0);
    issue(2'b00, 7'b0000011, 3'b000, 7'b0000000, 32'd3, 32'd4, 1'b1, acc);
    check("mflush_next_accept", {31'd0, acc}, 32'd1);
    drain();

    // Reset mid-MUL
    issue(2'b10, 7'b0110011, 3'b000, 7'b0000001, 32'hDEAD, 32'hBEEF, 1'b1, acc);
    repeat (5) @(posedge clk);
`else
    // Reset while holding a nonzero result
    issue(2'b10, 7'b0110011, 3'b110, 7'b0000000, 32'hF0, 32'h0F, 1'b0, acc);
`endif
    @(negedge clk);
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    sb.delete();
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'd0, zero}, 32'd1);
    check("arst_ctrl", {28'd0, ALUControl}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      case ($urandom_range(0, 3))
        0: f7r = 7'b0100000;
        1: f7r = 7'b0000001;
        2: f7r = 7'b0000000;
        default: f7r = 7'($urandom);
      endcase
      send(2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'($urandom),
           3'($urandom_range(0, 7)), f7r, a, b);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
